// File: rtl/c16_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// c16_pkg : arbiter state encoding and default memory access length
// Revision: 1.0
// ----------------------------------------------------------------------------
package c16_pkg;

  localparam int C16_MEM_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_ACC = 2'd1,
    ST_DL_ACC  = 2'd2
  } c16_state_t;

endpackage
`default_nettype wire

// File: rtl/c16_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// c16_mem_arbiter : shares one memory port between TED bus cycles and a loader
// Revision: 1.0
// ----------------------------------------------------------------------------
module c16_mem_arbiter
  import c16_pkg::*;
#(
  parameter int MEM_LAT = C16_MEM_LAT_DEFAULT
) (
  input  logic        CLK28,
  input  logic        RESET_N,
  input  logic        BUS_CAS,
  input  logic        BUS_RW,
  input  logic [15:0] BUS_ADDR,
  input  logic [7:0]  BUS_WDATA,
  output logic [7:0]  BUS_RDATA,
  input  logic        DL_REQ,
  input  logic [15:0] DL_ADDR,
  input  logic [7:0]  DL_DATA,
  output logic        DL_ACK,
  input  logic        DL_ACTIVE,
  output logic        WAIT,
  output logic        MEM_CE,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  output logic        OVERRUN
);

  localparam logic [2:0] C_LAST = 3'(MEM_LAT - 1);

  c16_state_t  state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        cas_q;
  logic        pend, pend_rw;
  logic [15:0] pend_addr;
  logic [7:0]  pend_wdata;

  logic        cas_fall, last;
  logic        ce_nxt, we_nxt, ack_nxt, pend_nxt, pend_load, ovr_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  wdata_nxt, rdata_nxt;

  assign cas_fall = cas_q & ~BUS_CAS;
  assign last     = (cnt == C_LAST);

  // cas_q tracks the pin even in reset so a CAS held low across release is not an edge
  always_ff @(posedge CLK28) begin
    cas_q <= BUS_CAS;
    if (!RESET_N) begin
      state      <= ST_IDLE;
      cnt        <= 3'd0;
      MEM_CE     <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= 16'h0000;
      MEM_WDATA  <= 8'h00;
      BUS_RDATA  <= 8'hFF;
      DL_ACK     <= 1'b0;
      WAIT       <= 1'b0;
      OVERRUN    <= 1'b0;
      pend       <= 1'b0;
      pend_rw    <= 1'b0;
      pend_addr  <= 16'h0000;
      pend_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      MEM_CE    <= ce_nxt;
      MEM_WE    <= we_nxt;
      MEM_ADDR  <= addr_nxt;
      MEM_WDATA <= wdata_nxt;
      BUS_RDATA <= rdata_nxt;
      DL_ACK    <= ack_nxt;
      WAIT      <= DL_ACTIVE | DL_REQ;
      OVERRUN   <= ovr_nxt;
      pend      <= pend_nxt;
      if (pend_load) begin
        pend_rw    <= BUS_RW;
        pend_addr  <= BUS_ADDR;
        pend_wdata <= BUS_WDATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = 3'd0;
    case (state)
      ST_IDLE: begin
        if (cas_fall || pend) state_nxt = ST_BUS_ACC;
        else if (DL_REQ)      state_nxt = ST_DL_ACC;
      end
      ST_BUS_ACC, ST_DL_ACC: begin
        if (last) state_nxt = ST_IDLE;
        else      cnt_nxt   = cnt + 3'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ce_nxt    = MEM_CE;
    we_nxt    = MEM_WE;
    addr_nxt  = MEM_ADDR;
    wdata_nxt = MEM_WDATA;
    rdata_nxt = BUS_RDATA;
    ack_nxt   = 1'b0;
    pend_nxt  = pend;
    pend_load = 1'b0;
    ovr_nxt   = OVERRUN;

    if (state == ST_IDLE) begin
      if (state_nxt == ST_BUS_ACC) begin
        ce_nxt = 1'b1;
        if (pend) begin
          we_nxt    = ~pend_rw;
          addr_nxt  = pend_addr;
          wdata_nxt = pend_wdata;
          pend_nxt  = 1'b0;
        end else begin
          we_nxt    = ~BUS_RW;
          addr_nxt  = BUS_ADDR;
          wdata_nxt = BUS_WDATA;
        end
      end else if (state_nxt == ST_DL_ACC) begin
        ce_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = DL_ADDR;
        wdata_nxt = DL_DATA;
      end
    end else if (last) begin
      ce_nxt = 1'b0;
      we_nxt = 1'b0;
      if (state == ST_BUS_ACC && !MEM_WE) rdata_nxt = MEM_RDATA;
    end

    // ack is registered so it is high during the final loader access cycle
    if (state_nxt == ST_DL_ACC && cnt_nxt == C_LAST) ack_nxt = 1'b1;

    if (cas_fall) begin
      if (state == ST_BUS_ACC || pend) begin
        ovr_nxt = 1'b1;
      end else if (state == ST_DL_ACC) begin
        pend_nxt  = 1'b1;
        pend_load = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c16_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_c16_mem_arbiter : table-driven and scoreboard bench for c16_mem_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_c16_mem_arbiter;

  localparam int LAT = 2;

  logic        CLK28, RESET_N, BUS_CAS, BUS_RW, DL_REQ, DL_ACTIVE;
  logic [15:0] BUS_ADDR, DL_ADDR, MEM_ADDR;
  logic [7:0]  BUS_WDATA, DL_DATA, BUS_RDATA, MEM_WDATA, MEM_RDATA;
  logic        DL_ACK, WAIT, MEM_CE, MEM_WE, OVERRUN;

  c16_mem_arbiter #(.MEM_LAT(LAT)) dut (
    .CLK28(CLK28), .RESET_N(RESET_N), .BUS_CAS(BUS_CAS), .BUS_RW(BUS_RW),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA),
    .DL_REQ(DL_REQ), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .DL_ACK(DL_ACK),
    .DL_ACTIVE(DL_ACTIVE), .WAIT(WAIT), .MEM_CE(MEM_CE), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .OVERRUN(OVERRUN)
  );

  // memory contents: fixed function of address, 1234 holds 5A
  assign MEM_RDATA = (MEM_ADDR == 16'h1234) ? 8'h5A : (MEM_ADDR[15:8] ^ MEM_ADDR[7:0]);

  initial CLK28 = 1'b0;
  always #5 CLK28 = ~CLK28;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK28);
    #1;
  endtask

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_cur;
  bit   mon_valid = 1'b0;
  bit   mon_rst   = 1'b0;
  bit   ce_prev   = 1'b0;
  int   mon_len   = 0;

  // access monitor: content on rise, stability while high, length on fall
  always @(negedge CLK28) begin
    if (RESET_N !== 1'b1) mon_rst = 1'b1;
    if (MEM_CE === 1'b1 && !ce_prev) begin
      mon_len = 1;
      mon_rst = (RESET_N !== 1'b1);
      check("sb_expected_access", exp_q.size() > 0, 1);
      mon_valid = (exp_q.size() > 0);
      if (mon_valid) begin
        mon_cur = exp_q.pop_front();
        check("sb_we", MEM_WE, mon_cur.we);
        check("sb_addr", MEM_ADDR, mon_cur.addr);
        check("sb_wdata", MEM_WDATA, mon_cur.wdata);
      end
    end else if (MEM_CE === 1'b1) begin
      mon_len++;
      if (mon_valid) begin
        check("stable_we", MEM_WE, mon_cur.we);
        check("stable_addr", MEM_ADDR, mon_cur.addr);
        check("stable_wdata", MEM_WDATA, mon_cur.wdata);
      end
    end else if (ce_prev && !mon_rst && mon_valid) begin
      check("ce_length", mon_len, LAT);
    end
    ce_prev = (MEM_CE === 1'b1);
  end

  task automatic do_bus(input logic rw, input logic [15:0] a, input logic [7:0] d);
    bit seen, done;
    seen = 1'b0;
    done = 1'b0;
    exp_q.push_back('{we: ~rw, addr: a, wdata: d});
    tick(); BUS_RW = rw; BUS_ADDR = a; BUS_WDATA = d; BUS_CAS = 1'b0;
    tick(); BUS_CAS = 1'b1; BUS_RW = ~rw; BUS_ADDR = ~a; BUS_WDATA = ~d;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK28);
      if (MEM_CE === 1'b1) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    check("bus_done", done, 1);
  endtask

  task automatic do_dl(input logic [15:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    exp_q.push_back('{we: 1'b1, addr: a, wdata: d});
    tick(); DL_REQ = 1'b1; DL_ADDR = a; DL_DATA = d;
    @(negedge CLK28);
    check("wait_before", WAIT, 0);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK28);
      if (k == 0) begin
        check("wait_after", WAIT, 1);
        check("ack_not_early", DL_ACK, 0);
      end
      if (DL_ACK === 1'b1) begin
        got = 1'b1;
        check("ack_in_last_cycle", MEM_CE, 1);
      end
    end
    check("dl_ack_seen", got, 1);
    tick(); DL_REQ = 1'b0; DL_ADDR = ~a; DL_DATA = ~d;
    @(negedge CLK28);
    check("ack_one_cycle", DL_ACK, 0);
  endtask

  typedef struct {
    bit          is_dl;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a;
    vecs[0] = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b0, 16'h1001, 8'hA5, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 16'h4321, 8'h77, 8'h5A};
    vecs[3] = '{1'b0, 1'b1, 16'hABCD, 8'h00, 8'h66};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h66};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 8'hFF, 8'h66};
    vecs[6] = '{1'b0, 1'b1, 16'h8001, 8'h00, 8'h81};

    RESET_N = 1'b0; BUS_CAS = 1'b1; BUS_RW = 1'b1; BUS_ADDR = 16'h0; BUS_WDATA = 8'h0;
    DL_REQ = 1'b0; DL_ADDR = 16'h0; DL_DATA = 8'h0; DL_ACTIVE = 1'b1;

    repeat (2) tick();
    @(negedge CLK28);
    check("rst_ce", MEM_CE, 0);
    check("rst_we", MEM_WE, 0);
    check("rst_addr", MEM_ADDR, 16'h0000);
    check("rst_wdata", MEM_WDATA, 8'h00);
    check("rst_rdata", BUS_RDATA, 8'hFF);
    check("rst_ack", DL_ACK, 0);
    check("rst_wait", WAIT, 0);
    check("rst_overrun", OVERRUN, 0);

    // CAS already low when reset releases: no request
    tick(); BUS_CAS = 1'b0;
    tick(); RESET_N = 1'b1; DL_ACTIVE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK28);
      check("no_spurious_ce", MEM_CE, 0);
    end
    tick(); BUS_CAS = 1'b1;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].is_dl) do_dl(vecs[i].addr, vecs[i].data);
      else               do_bus(vecs[i].rw, vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_rdata", i), BUS_RDATA, vecs[i].exp_rdata);
    end
    check("idle_addr_hold", MEM_ADDR, 16'h8001);
    check("idle_we", MEM_WE, 0);

    tick(); DL_ACTIVE = 1'b1;
    @(negedge CLK28); check("wait_lag", WAIT, 0);
    tick(); DL_ACTIVE = 1'b0;
    @(negedge CLK28); check("wait_active", WAIT, 1);
    tick();
    @(negedge CLK28); check("wait_release", WAIT, 0);

    // simultaneous CAS fall and loader request: bus first
    exp_q.push_back('{we: 1'b0, addr: 16'h00AA, wdata: 8'h00});
    exp_q.push_back('{we: 1'b1, addr: 16'h3003, wdata: 8'h99});
    tick(); BUS_RW = 1'b1; BUS_ADDR = 16'h00AA; BUS_WDATA = 8'h00; BUS_CAS = 1'b0;
    DL_REQ = 1'b1; DL_ADDR = 16'h3003; DL_DATA = 8'h99;
    tick(); BUS_CAS = 1'b1;
    s = -1; a = -1;
    for (int k = 1; k <= 20 && a < 0; k++) begin
      @(negedge CLK28);
      if (MEM_CE === 1'b1 && s < 0) s = k;
      if (DL_ACK === 1'b1) a = k;
    end
    check("simul_ack_seen", a > 0, 1);
    check("simul_ack_delay", a - s, 4);
    tick(); DL_REQ = 1'b0;
    @(negedge CLK28);
    check("simul_rdata", BUS_RDATA, 8'hAA);

    // CAS fall on first loader cycle: pended, then served after the loader
    exp_q.push_back('{we: 1'b1, addr: 16'h5005, wdata: 8'h11});
    exp_q.push_back('{we: 1'b1, addr: 16'h2000, wdata: 8'h3C});
    tick(); DL_REQ = 1'b1; DL_ADDR = 16'h5005; DL_DATA = 8'h11;
    tick(); BUS_RW = 1'b0; BUS_ADDR = 16'h2000; BUS_WDATA = 8'h3C; BUS_CAS = 1'b0;
    tick(); BUS_CAS = 1'b1; BUS_RW = 1'b1; BUS_ADDR = 16'h0000; BUS_WDATA = 8'h00;
    @(negedge CLK28); check("coll_ack", DL_ACK, 1);
    tick(); DL_REQ = 1'b0;
    @(negedge CLK28); check("coll_gap", MEM_CE, 0);
    tick();
    @(negedge CLK28);
    check("coll_bus_ce", MEM_CE, 1);
    check("coll_bus_addr", MEM_ADDR, 16'h2000);
    tick(); tick();
    @(negedge CLK28);
    check("coll_overrun", OVERRUN, 0);
    check("coll_rdata", BUS_RDATA, 8'hAA);

    // second CAS fall inside a bus access
    check("ovr_before", OVERRUN, 0);
    exp_q.push_back('{we: 1'b0, addr: 16'h1234, wdata: 8'hC3});
    tick(); BUS_RW = 1'b1; BUS_ADDR = 16'h1234; BUS_WDATA = 8'hC3; BUS_CAS = 1'b0;
    tick(); BUS_CAS = 1'b1;
    tick(); BUS_CAS = 1'b0; BUS_ADDR = 16'h7777;
    tick(); BUS_CAS = 1'b1;
    @(negedge CLK28);
    check("ovr_set", OVERRUN, 1);
    check("ovr_idle", MEM_CE, 0);
    repeat (4) tick();
    @(negedge CLK28);
    check("ovr_hold", OVERRUN, 1);
    check("ovr_rdata", BUS_RDATA, 8'h5A);
    tick(); RESET_N = 1'b0;
    tick();
    @(negedge CLK28);
    check("ovr_cleared", OVERRUN, 0);
    check("rst2_rdata", BUS_RDATA, 8'hFF);
    check("rst2_addr", MEM_ADDR, 16'h0000);
    check("rst2_wdata", MEM_WDATA, 8'h00);
    tick(); RESET_N = 1'b1;

    // reset during a loader access aborts it
    exp_q.push_back('{we: 1'b1, addr: 16'h6006, wdata: 8'h42});
    tick(); DL_REQ = 1'b1; DL_ADDR = 16'h6006; DL_DATA = 8'h42;
    tick();
    @(negedge CLK28);
    check("rstdl_started", MEM_CE, 1);
    RESET_N = 1'b0;
    tick(); DL_REQ = 1'b0;
    @(negedge CLK28);
    check("rstdl_ce", MEM_CE, 0);
    tick(); RESET_N = 1'b1;
    a = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK28);
      if (DL_ACK === 1'b1) a++;
    end
    check("rstdl_no_ack", a, 0);
    check("rstdl_rdata", BUS_RDATA, 8'hFF);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
